h264_bit_unpacker: RTL and testbench
====================================

Name: h264_bit_unpacker

Overview:
- Bitstream reader for the H.264 path. It is the consumer end of the packer's 32-bit output stream (output_valid / output_data32): 32-bit words in, MSB-first bit order.
- Serves parse commands one at a time: fixed-length read, ue(v), se(v) and byte-align.
- Sits between a word source (DMA or buffer) and a future slice-header/CAVLC parser. It is also used to self-check packer output in simulation.

Parameters:
- MAX_LZ, 15: maximum Exp-Golomb leading zeros. Legal range 1..15.
- BYTE_SWAP, 0: 1 = byte-reverse each input word before buffering.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear, highest priority
- in_valid  in  1  input word valid
- in_data  in  32  input word, bit 31 first
- in_ready  out  1  word accepted when in_valid && in_ready
- cmd_valid  in  1  command valid
- cmd_op  in  2  00 read, 01 ue, 10 se, 11 align
- cmd_len  in  6  bit count for read (0..32)
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- rsp_valid  out  1  result valid, held until rsp_ready
- rsp_data  out  32  result, right-aligned
- rsp_err  out  1  ue/se overflow for this response
- rsp_ready  in  1  result consumed
- bits_avail  out  7  buffered bit count (0..64)
- bits_consumed  out  32  total bits consumed since reset/flush, wraps mod 2^32

Behaviour:
- Reset (async, rst_n=0) and flush (sync) clear all state:
  - buf=0, cnt=0, bitpos=0, bits_consumed=0, state=IDLE.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - in_ready=0 while flush=1; cmd_ready=1 after.
- Buffer: 64-bit MSB-aligned shift register; cnt = valid bits.
  - in_ready = (cnt <= 32) && !flush.
  - On in_fire the word is written at bits [63-c':32-c'], where c' = cnt - consumed_this_cycle.
  - cnt_next = cnt - consumed + (in_fire ? 32 : 0). Simultaneous consume and append is legal.
- FSM IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: cmd_ready=1. On cmd fire, latch op/len and go to EXEC.
  - EXEC: evaluate against the current buf/cnt. If bits are insufficient, stay in EXEC (stall indefinitely, no timeout). Otherwise consume n bits, register rsp_data/rsp_err, set rsp_valid, go to RESP.
  - RESP: when rsp_ready, clear rsp_valid and go to IDLE.
  - Minimum latency: cmd fire at cycle T gives rsp_valid at T+2. Throughput is 1 command per 3 cycles.
- read:
  - len 1..32: needs cnt>=len. rsp_data = top len bits, zero-extended.
  - len 0: immediate, rsp_data=0, n=0.
  - len >32: treated as 32.
- ue:
  - lz = leading zeros of buf.
  - Needs a 1 within the first MAX_LZ+1 bits and cnt >= 2*lz+1.
  - codeNum = 2^lz - 1 + next lz bits; n = 2*lz+1.
  - If the first MAX_LZ+1 bits are buffered and all zero: rsp_err=1, rsp_data=0, n=0.
- se:
  - Same as ue, then map k: k odd -> (k+1)/2; k even -> -(k/2), 32-bit two's complement.
  - Error handling identical to ue.
- align:
  - n = (8 - bitpos) & 7; needs cnt >= n. rsp_data = n (0..7).
- Any consumption of n bits: bitpos += n (mod 8), bits_consumed += n.
- Reset or flush in the middle of EXEC/RESP abandons the command; no response is issued.
- bits_avail = cnt, registered.

Test Plan:
- Push 0xA5000000; read len 8 -> rsp_data 0x000000A5, bits_consumed 8, bits_avail 24; rsp_valid at T+2.
- Push 0x38000000; ue -> rsp_data 6, consumed 5, rsp_err 0.
- Push 0x21400000; se, se -> rsp_data 0x00000002, then 0xFFFFFFFE; bits_consumed 10.
- Push 0xE0000000; read len 3 (rsp 7), then align -> rsp_data 5, bits_consumed 8. A second align -> rsp_data 0.
- Starvation and span:
  - Read len 24 with empty buffer -> no rsp_valid for 20 cycles.
  - Push 0x12345678 at cycle T -> rsp_data 0x00123456 at T+2.
  - Push 0x9ABCDEF0, then read 32 -> rsp_data 0x789ABCDE.
- Error and flush: push 0x00000000, 0x00000000; ue -> rsp_err 1, rsp_data 0, bits_avail 64, in_ready 0. Flush -> bits_avail 0, bits_consumed 0, in_ready 1, rsp_err 0.

Source files
------------

// File: rtl/h264_bit_unpacker.sv
// H.264 bitstream unpacker: buffers 32-bit MSB-first words in a 64-bit
// left-aligned shift register and serves one parse command at a time
// (fixed-length read, ue(v), se(v), byte-align).
module h264_bit_unpacker #(
  parameter int MAX_LZ    = 15,   // Exp-Golomb leading-zero limit, 1..15
  parameter bit BYTE_SWAP = 1'b0  // byte-reverse each incoming word
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_len,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic [6:0]  bits_avail,
  output logic [31:0] bits_consumed
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_UE    = 2'b01;
  localparam logic [1:0] OP_SE    = 2'b10;
  localparam logic [1:0] OP_ALIGN = 2'b11;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_buf;        // valid bits live at [63 -: r_cnt], rest is zero
  logic [6:0]  r_cnt;
  logic [2:0]  r_bitpos;
  logic [31:0] r_consumed;
  logic [1:0]  r_op;
  logic [5:0]  r_len;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;

  logic        w_in_fire, w_cmd_fire;
  logic [31:0] w_word;
  logic [4:0]  w_lz;
  logic        w_lz_found;
  logic [6:0]  w_eg_len;
  logic [31:0] w_mask, w_info, w_code, w_se;
  logic [5:0]  w_rlen;
  logic [31:0] w_rdata;
  logic [2:0]  w_alen;
  logic        w_ok, w_err;
  logic [6:0]  w_n;
  logic [31:0] w_res;
  logic        w_exec_done;
  logic [6:0]  w_take, w_cnt_rem, w_cnt_nxt;
  logic [63:0] w_buf_nxt;

  assign in_ready      = (r_cnt <= 7'd32) && !flush;
  assign cmd_ready     = (r_state == S_IDLE) && !flush;
  assign w_in_fire     = in_valid && in_ready;
  assign w_cmd_fire    = cmd_valid && cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_err       = r_rsp_err;
  assign bits_avail    = r_cnt;
  assign bits_consumed = r_consumed;

  assign w_word = BYTE_SWAP ? {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]}
                            : in_data;

  // Leading-zero count over the first MAX_LZ+1 buffered bits; lowest index wins.
  always_comb begin
    w_lz       = '0;
    w_lz_found = 1'b0;
    for (int i = MAX_LZ; i >= 0; i--) begin
      if (r_buf[63-i]) begin
        w_lz       = 5'(i);
        w_lz_found = 1'b1;
      end
    end
  end

  // Exp-Golomb decode: info bits sit right after the leading one, so the
  // low lz bits of buf >> (63 - 2*lz) are exactly the suffix.
  assign w_eg_len = {1'b0, w_lz, 1'b0} + 7'd1;
  assign w_mask   = (32'd1 << w_lz) - 32'd1;
  assign w_info   = 32'(r_buf >> (7'd63 - {1'b0, w_lz, 1'b0})) & w_mask;
  assign w_code   = w_mask + w_info;
  assign w_se     = w_code[0] ? ((w_code + 32'd1) >> 1) : (32'd0 - (w_code >> 1));

  // Fixed-length read clamps to 32; a shift of 64 yields zero for len 0.
  assign w_rlen  = (r_len > 6'd32) ? 6'd32 : r_len;
  assign w_rdata = 32'(r_buf >> (7'd64 - {1'b0, w_rlen}));

  // Bits remaining to the next byte boundary.
  assign w_alen = 3'd0 - r_bitpos;

  // Command evaluation against the current buffer: sufficiency, size, result.
  always_comb begin
    w_ok  = 1'b0;
    w_err = 1'b0;
    w_n   = '0;
    w_res = '0;
    case (r_op)
      OP_READ: begin
        w_n   = {1'b0, w_rlen};
        w_ok  = r_cnt >= {1'b0, w_rlen};
        w_res = w_rdata;
      end
      OP_UE, OP_SE: begin
        if (w_lz_found) begin
          w_n   = w_eg_len;
          w_ok  = r_cnt >= w_eg_len;
          w_res = (r_op == OP_SE) ? w_se : w_code;
        end else begin
          // Prefix longer than MAX_LZ: report once enough zeros are buffered.
          w_ok  = r_cnt >= 7'(MAX_LZ + 1);
          w_err = 1'b1;
        end
      end
      default: begin
        w_n   = {4'd0, w_alen};
        w_ok  = r_cnt >= {4'd0, w_alen};
        w_res = {29'd0, w_alen};
      end
    endcase
  end

  assign w_exec_done = (r_state == S_EXEC) && w_ok;
  assign w_take      = w_exec_done ? w_n : 7'd0;

  // Consume first, then append the new word right behind the survivors.
  assign w_cnt_rem = r_cnt - w_take;
  assign w_buf_nxt = (r_buf << w_take) |
                     (w_in_fire ? ({w_word, 32'd0} >> w_cnt_rem) : 64'd0);
  assign w_cnt_nxt = w_cnt_rem + (w_in_fire ? 7'd32 : 7'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: one command in flight, response held until taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_fire)  w_state_nxt = S_EXEC;
      S_EXEC:  if (w_exec_done) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready)   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // Buffer, counters, latched command and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= '0;
      r_cnt       <= '0;
      r_bitpos    <= '0;
      r_consumed  <= '0;
      r_op        <= '0;
      r_len       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (flush) begin
      r_buf       <= '0;
      r_cnt       <= '0;
      r_bitpos    <= '0;
      r_consumed  <= '0;
      r_op        <= '0;
      r_len       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_buf      <= w_buf_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bitpos   <= r_bitpos + w_take[2:0];
      r_consumed <= r_consumed + {25'd0, w_take};
      if (w_cmd_fire) begin
        r_op  <= cmd_op;
        r_len <= cmd_len;
      end
      if (w_exec_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_res;
        r_rsp_err   <= w_err;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_h264_bit_unpacker.sv
// Bench for h264_bit_unpacker: directed scenarios plus a randomized run
// against a bit-queue reference model, responses checked by a scoreboard.
module tb_h264_bit_unpacker;

  localparam int MAX_LZ = 15;
  localparam int NW     = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_ready;
  logic [6:0]  bits_avail;
  logic [31:0] bits_consumed;

  h264_bit_unpacker #(.MAX_LZ(MAX_LZ), .BYTE_SWAP(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .bits_avail(bits_avail), .bits_consumed(bits_consumed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 1'b0;

  typedef struct { logic [31:0] d; logic e; } exp_t;
  exp_t sb[$];

  // Reference model: the whole stream as a bit queue plus a read pointer.
  bit mq[$];
  int mpos  = 0;
  int mcons = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic e);
    exp_t x;
    x.d = d;
    x.e = e;
    sb.push_back(x);
  endtask

  function automatic void model_exec(input int op, input int len,
                                     output logic [31:0] d, output logic e);
    int n, lz, k, info;
    d = '0; e = 1'b0; n = 0;
    case (op)
      0: begin
        n = (len > 32) ? 32 : len;
        for (int i = 0; i < n; i++) d = {d[30:0], mq[mpos+i]};
      end
      1, 2: begin
        lz = 0;
        while (lz <= MAX_LZ && mq[mpos+lz] == 1'b0) lz++;
        if (lz > MAX_LZ) e = 1'b1;
        else begin
          info = 0;
          for (int i = 0; i < lz; i++) info = info * 2 + int'(mq[mpos+lz+1+i]);
          k = (1 << lz) - 1 + info;
          n = 2 * lz + 1;
          if (op == 1)          d = k;
          else if (k % 2 == 1)  d = (k + 1) / 2;
          else                  d = -(k / 2);
        end
      end
      default: begin
        n = (8 - (mcons % 8)) % 8;
        d = n;
      end
    endcase
    mpos  += n;
    mcons += n;
  endfunction

  // Scoreboard monitor: every accepted response pops one expectation.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %h with nothing expected", rsp_data);
      end else begin
        x = sb.pop_front();
        chk("rsp_data", rsp_data, x.d);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, x.e});
      end
    end
  end

  // rsp_ready: held high for directed tests, random backpressure otherwise.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic push_word(input logic [31:0] w, output int fcyc);
    int t = 0;
    in_valid = 1'b1;
    in_data  = w;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++t > 3000) begin fail_now("push_word"); break; end
    end
    @(posedge clk);
    #1;
    fcyc     = cyc;
    in_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [5:0] len, output int fcyc);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++t > 3000) begin fail_now("send_cmd"); break; end
    end
    @(posedge clk);
    #1;
    fcyc      = cyc;
    cmd_valid = 1'b0;
  endtask

  // Waits for rsp_valid; the response shows up one edge after the firing
  // edge, i.e. in cycle T+2 when the fire happened in cycle T.
  task automatic wait_rsp(input int ref_cyc, input int lat, input string nm);
    int t = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      if (++t > 200) begin fail_now(nm); return; end
    end
    if (lat >= 0) chk(nm, cyc - ref_cyc, lat);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    mq.delete();
    mpos  = 0;
    mcons = 0;
  endtask

  initial begin
    int f, d, seen;
    int remaining, iter, op, len, t;
    logic [31:0] md;
    logic me;
    logic [31:0] words[NW];

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_bits_avail", {25'd0, bits_avail}, 32'd0);
    chk("reset_bits_consumed", bits_consumed, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Fixed-length read and its latency.
    push_word(32'hA5000000, d);
    expect_rsp(32'h000000A5, 1'b0);
    send_cmd(2'b00, 6'd8, f);
    wait_rsp(f, 1, "read8_latency");
    chk("read8_consumed", bits_consumed, 32'd8);
    chk("read8_avail", {25'd0, bits_avail}, 32'd24);
    @(posedge clk); #1;

    // ue(v)
    do_flush();
    push_word(32'h38000000, d);
    expect_rsp(32'd6, 1'b0);
    send_cmd(2'b01, 6'd0, f);
    wait_rsp(f, 1, "ue_latency");
    chk("ue_consumed", bits_consumed, 32'd5);
    @(posedge clk); #1;

    // se(v) positive then negative
    do_flush();
    push_word(32'h21400000, d);
    expect_rsp(32'h00000002, 1'b0);
    send_cmd(2'b10, 6'd0, f);
    wait_rsp(f, 1, "se1_latency");
    expect_rsp(32'hFFFFFFFE, 1'b0);
    send_cmd(2'b10, 6'd0, f);
    wait_rsp(f, 1, "se2_latency");
    chk("se_consumed", bits_consumed, 32'd10);
    @(posedge clk); #1;

    // read 3 then align twice
    do_flush();
    push_word(32'hE0000000, d);
    expect_rsp(32'd7, 1'b0);
    send_cmd(2'b00, 6'd3, f);
    wait_rsp(f, -1, "read3");
    expect_rsp(32'd5, 1'b0);
    send_cmd(2'b11, 6'd0, f);
    wait_rsp(f, -1, "align1");
    chk("align_consumed", bits_consumed, 32'd8);
    expect_rsp(32'd0, 1'b0);
    send_cmd(2'b11, 6'd0, f);
    wait_rsp(f, -1, "align2");
    @(posedge clk); #1;

    // Starvation, then a read spanning two words
    do_flush();
    expect_rsp(32'h00123456, 1'b0);
    send_cmd(2'b00, 6'd24, f);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    chk("starve_no_rsp", seen, 32'd0);
    @(posedge clk); #1;
    push_word(32'h12345678, f);
    wait_rsp(f, 1, "starve_push_latency");
    @(posedge clk); #1;
    push_word(32'h9ABCDEF0, d);
    expect_rsp(32'h789ABCDE, 1'b0);
    send_cmd(2'b00, 6'd32, f);
    wait_rsp(f, 1, "span_latency");
    @(posedge clk); #1;

    // Overflow error, then flush
    do_flush();
    push_word(32'h0, d);
    push_word(32'h0, d);
    expect_rsp(32'd0, 1'b1);
    send_cmd(2'b01, 6'd0, f);
    wait_rsp(f, 1, "ue_err_latency");
    chk("err_avail", {25'd0, bits_avail}, 32'd64);
    chk("err_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_avail", {25'd0, bits_avail}, 32'd0);
    chk("flush_consumed", bits_consumed, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1;

    // Randomized stream and commands with response backpressure
    mq.delete(); mpos = 0; mcons = 0;
    for (int i = 0; i < NW; i++) begin
      case ($urandom_range(0, 3))
        0:       words[i] = $urandom;
        1:       words[i] = $urandom & $urandom & $urandom;
        2:       words[i] = 32'h0;
        default: words[i] = $urandom >> $urandom_range(0, 31);
      endcase
      for (int b = 31; b >= 0; b--) mq.push_back(words[i][b]);
    end
    rnd_ready = 1'b1;
    fork
      begin
        int ff;
        for (int i = 0; i < NW; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          push_word(words[i], ff);
        end
      end
      begin
        int fc;
        iter = 0;
        remaining = NW * 32 - mpos;
        while (remaining >= 40) begin
          if (iter > 800) begin op = 0; len = 32; end
          else begin op = $urandom_range(0, 3); len = $urandom_range(0, 40); end
          model_exec(op, len, md, me);
          expect_rsp(md, me);
          send_cmd(op[1:0], len[5:0], fc);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          iter++;
          remaining = NW * 32 - mpos;
        end
      end
    join
    t = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      if (++t > 2000) begin fail_now("drain"); break; end
    end
    rnd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rand_consumed", bits_consumed, mcons);
    chk("rand_avail", {25'd0, bits_avail}, NW * 32 - mcons);
    chk("rand_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
